// File: rtl/gpr_wb_pkg.sv
// gpr_wb_pkg: shared configuration and types for the GPR writeback arbiter.
//   - default configuration values (units, lanes, warps, registers, lane width)
//   - width derivation helpers for the warp id, register index and pointer
//   - wb_entry_t: one writeback record {wid, tmask, rd, data} at the default
//     configuration, for consumers of the writeback stream
package gpr_wb_pkg;

    localparam int NUM_UNITS_DEF   = 4;
    localparam int NUM_THREADS_DEF = 4;
    localparam int NUM_WARPS_DEF   = 4;
    localparam int NUM_REGS_DEF    = 32;
    localparam int DATAW_DEF       = 32;

    // Warp id width; a single-warp core still carries a 1-bit field.
    function automatic int calc_wid_w(input int num_warps);
        return (num_warps > 1) ? $clog2(num_warps) : 1;
    endfunction

    // Register index width.
    function automatic int calc_rd_w(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    // Index width for selecting one of n sources.
    function automatic int calc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int WID_W_DEF = calc_wid_w(NUM_WARPS_DEF);
    localparam int RD_W_DEF  = calc_rd_w(NUM_REGS_DEF);

    typedef struct packed {
        logic [WID_W_DEF-1:0]                 wid;
        logic [NUM_THREADS_DEF-1:0]           tmask;
        logic [RD_W_DEF-1:0]                  rd;
        logic [NUM_THREADS_DEF*DATAW_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// gpr_wb_arbiter_if: commit-side and writeback-side bundle of the arbiter.
//   cmt_*  : NUM_UNITS flattened commit streams (valid/ready/wid/tmask/rd/data)
//   wb_*   : single writeback stream towards the GPR file
// Modports:
//   slave  : arbiter view (consumes commits, produces writebacks)
//   master : environment view (produces commits, consumes writebacks)
interface gpr_wb_arbiter_if
    import gpr_wb_pkg::*;
#(
    parameter int NUM_UNITS   = NUM_UNITS_DEF,
    parameter int NUM_THREADS = NUM_THREADS_DEF,
    parameter int NUM_WARPS   = NUM_WARPS_DEF,
    parameter int NUM_REGS    = NUM_REGS_DEF,
    parameter int DATAW       = DATAW_DEF
);
    localparam int WID_W = calc_wid_w(NUM_WARPS);
    localparam int RD_W  = calc_rd_w(NUM_REGS);

    logic [NUM_UNITS-1:0]                   cmt_valid_i;
    logic [NUM_UNITS-1:0]                   cmt_ready_o;
    logic [NUM_UNITS*WID_W-1:0]             cmt_wid_i;
    logic [NUM_UNITS*NUM_THREADS-1:0]       cmt_tmask_i;
    logic [NUM_UNITS*RD_W-1:0]              cmt_rd_i;
    logic [NUM_UNITS*NUM_THREADS*DATAW-1:0] cmt_data_i;

    logic                                   wb_valid_o;
    logic                                   wb_ready_i;
    logic [WID_W-1:0]                       wb_wid_o;
    logic [NUM_THREADS-1:0]                 wb_tmask_o;
    logic [RD_W-1:0]                        wb_rd_o;
    logic [NUM_THREADS*DATAW-1:0]           wb_data_o;

    modport slave (
        input  cmt_valid_i, cmt_wid_i, cmt_tmask_i, cmt_rd_i, cmt_data_i,
        output cmt_ready_o,
        output wb_valid_o, wb_wid_o, wb_tmask_o, wb_rd_o, wb_data_o,
        input  wb_ready_i
    );

    modport master (
        output cmt_valid_i, cmt_wid_i, cmt_tmask_i, cmt_rd_i, cmt_data_i,
        input  cmt_ready_o,
        input  wb_valid_o, wb_wid_o, wb_tmask_o, wb_rd_o, wb_data_o,
        output wb_ready_i
    );

endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin arbiter with a registered priority pointer.
// Ports:
//   clk_i       clock
//   rst_ni      synchronous active-low reset (pointer returns to 0)
//   req_i       N request bits
//   adv_i       a grant was consumed this cycle; pointer moves past the winner
//   grant_o     one-hot grant (combinational, zero when no request)
//   grant_idx_o index of the granted request
module wb_rr_arbiter
    import gpr_wb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = calc_idx_w(N)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N-1:0]     req_i,
    input  logic             adv_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    logic [IDX_W-1:0] ptr_r;
    logic [N-1:0]     grant_s;
    logic [IDX_W-1:0] grant_idx_s;
    logic [IDX_W-1:0] ptr_next_s;

    // Scan requests starting at the pointer, wrapping N-1 -> 0; first hit wins.
    always_comb begin
        logic found;
        grant_s     = '0;
        grant_idx_s = '0;
        found       = 1'b0;
        for (int k = 0; k < N; k++) begin
            int u;
            u = int'(ptr_r) + k;
            if (u >= N) begin
                u = u - N;
            end else begin
                u = u;
            end
            if (!found && req_i[u]) begin
                grant_s[u]  = 1'b1;
                grant_idx_s = u[IDX_W-1:0];
                found       = 1'b1;
            end else begin
                found = found;
            end
        end
    end

    // Next pointer is one past the winner, wrapping; with N=1 it stays 0.
    always_comb begin
        if (grant_idx_s == IDX_W'(N - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = grant_idx_s + IDX_W'(1);
        end
    end

    // Priority pointer register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_r <= '0;
        end else if (adv_i) begin
            ptr_r <= ptr_next_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign grant_o     = grant_s;
    assign grant_idx_o = grant_idx_s;

endmodule

// File: rtl/gpr_wb_arbiter.sv
// gpr_wb_arbiter: merges NUM_UNITS commit streams into the single GPR
// writeback stream through round-robin arbitration and one output register.
// Ports:
//   clk_i   clock
//   rst_ni  synchronous active-low reset
//   bus     gpr_wb_arbiter_if.slave (cmt_* inputs, cmt_ready_o, wb_* outputs)
// Optional (macro WB_ARB_PERF_EN):
//   perf_wb_count_o        writeback handshakes (wb_valid && wb_ready)
//   perf_conflict_count_o  cycles with more than one commit valid and a free slot
// Commits to register 0 are consumed without producing a writeback pulse.
module gpr_wb_arbiter
    import gpr_wb_pkg::*;
#(
    parameter int NUM_UNITS   = NUM_UNITS_DEF,
    parameter int NUM_THREADS = NUM_THREADS_DEF,
    parameter int NUM_WARPS   = NUM_WARPS_DEF,
    parameter int NUM_REGS    = NUM_REGS_DEF,
    parameter int DATAW       = DATAW_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    gpr_wb_arbiter_if.slave       bus
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]           perf_wb_count_o,
    output logic [31:0]           perf_conflict_count_o
`endif
);

    localparam int WID_W  = calc_wid_w(NUM_WARPS);
    localparam int RD_W   = calc_rd_w(NUM_REGS);
    localparam int IDX_W  = calc_idx_w(NUM_UNITS);
    localparam int LDATAW = NUM_THREADS * DATAW;

    typedef struct packed {
        logic [WID_W-1:0]       wid;
        logic [NUM_THREADS-1:0] tmask;
        logic [RD_W-1:0]        rd;
        logic [LDATAW-1:0]      data;
    } wb_slot_t;

    logic [NUM_UNITS-1:0] grant_s;
    logic [IDX_W-1:0]     grant_idx_s;
    logic                 slot_free_s;
    logic                 ready_en_s;
    logic                 accept_s;
    wb_slot_t             sel_s;
    wb_slot_t             wb_slot_r;
    logic                 wb_valid_r;

    // A new commit may enter when the output register is empty or draining.
    assign slot_free_s      = !wb_valid_r || bus.wb_ready_i;
    assign ready_en_s       = rst_ni && slot_free_s;
    assign bus.cmt_ready_o  = grant_s & {NUM_UNITS{ready_en_s}};
    assign accept_s         = |(bus.cmt_valid_i & bus.cmt_ready_o);

    wb_rr_arbiter #(
        .N     (NUM_UNITS),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (bus.cmt_valid_i),
        .adv_i       (accept_s),
        .grant_o     (grant_s),
        .grant_idx_o (grant_idx_s)
    );

    // Select the granted unit's payload from the flattened commit buses.
    always_comb begin
        sel_s       = '0;
        sel_s.wid   = bus.cmt_wid_i[grant_idx_s*WID_W +: WID_W];
        sel_s.tmask = bus.cmt_tmask_i[grant_idx_s*NUM_THREADS +: NUM_THREADS];
        sel_s.rd    = bus.cmt_rd_i[grant_idx_s*RD_W +: RD_W];
        sel_s.data  = bus.cmt_data_i[grant_idx_s*LDATAW +: LDATAW];
    end

    // Output stage: load on accept, drop valid once drained, hold under stall.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wb_valid_r <= 1'b0;
            wb_slot_r  <= '0;
        end else if (accept_s) begin
            wb_valid_r <= (sel_s.rd != '0);
            wb_slot_r  <= sel_s;
        end else if (slot_free_s) begin
            wb_valid_r <= 1'b0;
            wb_slot_r  <= wb_slot_r;
        end else begin
            wb_valid_r <= wb_valid_r;
            wb_slot_r  <= wb_slot_r;
        end
    end

    assign bus.wb_valid_o = wb_valid_r;
    assign bus.wb_wid_o   = wb_slot_r.wid;
    assign bus.wb_tmask_o = wb_slot_r.tmask;
    assign bus.wb_rd_o    = wb_slot_r.rd;
    assign bus.wb_data_o  = wb_slot_r.data;

`ifdef WB_ARB_PERF_EN
    localparam logic [NUM_UNITS-1:0] ONE_U = NUM_UNITS'(1);

    logic [31:0] perf_wb_cnt_r;
    logic [31:0] perf_conf_cnt_r;

    // True when two or more bits of v are set (clearing the lowest leaves some).
    function automatic logic multi_hot(input logic [NUM_UNITS-1:0] v);
        return |(v & (v - ONE_U));
    endfunction

    // Performance counters, free-running and wrapping at 2^32.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            perf_wb_cnt_r   <= 32'd0;
            perf_conf_cnt_r <= 32'd0;
        end else begin
            if (wb_valid_r && bus.wb_ready_i) begin
                perf_wb_cnt_r <= perf_wb_cnt_r + 32'd1;
            end else begin
                perf_wb_cnt_r <= perf_wb_cnt_r;
            end
            if (multi_hot(bus.cmt_valid_i) && slot_free_s) begin
                perf_conf_cnt_r <= perf_conf_cnt_r + 32'd1;
            end else begin
                perf_conf_cnt_r <= perf_conf_cnt_r;
            end
        end
    end

    assign perf_wb_count_o       = perf_wb_cnt_r;
    assign perf_conflict_count_o = perf_conf_cnt_r;
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb_gpr_wb_arbiter: directed self-checking bench for gpr_wb_arbiter
// (default configuration: 4 units, 4 lanes, 4 warps, 32 regs, 32-bit lanes).
// Build with WB_ARB_PERF_EN defined to also exercise the performance counters.
module tb_gpr_wb_arbiter;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    gpr_wb_arbiter_if #(
        .NUM_UNITS(4), .NUM_THREADS(4), .NUM_WARPS(4), .NUM_REGS(32), .DATAW(32)
    ) bus ();

`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_wb;
    logic [31:0] perf_conf;
`endif

    gpr_wb_arbiter #(
        .NUM_UNITS(4), .NUM_THREADS(4), .NUM_WARPS(4), .NUM_REGS(32), .DATAW(32)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_wb_count_o       (perf_wb),
        .perf_conflict_count_o (perf_conf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_unit(input int u, input logic [1:0] wid, input logic [3:0] tm,
                            input logic [4:0] rd, input logic [127:0] data);
        bus.cmt_wid_i[u*2 +: 2]     = wid;
        bus.cmt_tmask_i[u*4 +: 4]   = tm;
        bus.cmt_rd_i[u*5 +: 5]      = rd;
        bus.cmt_data_i[u*128 +: 128] = data;
    endtask

    initial begin
        logic [127:0] d2;
        n_assert = 0;
        n_fail   = 0;
        d2 = 128'hA5A50004_A5A50003_A5A50002_A5A50001;

        rst_n              = 1'b0;
        bus.wb_ready_i     = 1'b1;
        bus.cmt_valid_i    = 4'hF;
        bus.cmt_wid_i      = '0;
        bus.cmt_tmask_i    = '0;
        bus.cmt_rd_i       = '0;
        bus.cmt_data_i     = '0;
        for (int u = 0; u < 4; u++) begin
            set_unit(u, 2'(u), 4'hF, 5'(u + 1), {4{32'hD000_0000 + 32'(u)}});
        end
        tick();
        tick();
        chk("reset_wb_valid", {127'd0, bus.wb_valid_o}, 128'd0);
        chk("reset_wb_rd",    {123'd0, bus.wb_rd_o},    128'd0);
        chk("reset_wb_data",  bus.wb_data_o,            128'd0);
        chk("reset_cmt_ready", {124'd0, bus.cmt_ready_o}, 128'd0);

        // All four units valid: round-robin order 0,1,2,3,0.
        rst_n = 1'b1;
        #1;
        chk("rr_first_ready", {124'd0, bus.cmt_ready_o}, 128'h1);
        tick();
        chk("rr0_valid", {127'd0, bus.wb_valid_o}, 128'd1);
        chk("rr0_rd",    {123'd0, bus.wb_rd_o},    128'd1);
        chk("rr0_wid",   {126'd0, bus.wb_wid_o},   128'd0);
        chk("rr0_data",  bus.wb_data_o, {4{32'hD000_0000}});
        chk("rr1_ready", {124'd0, bus.cmt_ready_o}, 128'h2);
        tick();
        chk("rr1_rd",    {123'd0, bus.wb_rd_o},    128'd2);
        chk("rr2_ready", {124'd0, bus.cmt_ready_o}, 128'h4);
        tick();
        chk("rr2_rd",    {123'd0, bus.wb_rd_o},    128'd3);
        chk("rr3_ready", {124'd0, bus.cmt_ready_o}, 128'h8);
        tick();
        chk("rr3_rd",    {123'd0, bus.wb_rd_o},    128'd4);
        chk("rr3_wid",   {126'd0, bus.wb_wid_o},   128'd3);
        chk("rr4_ready", {124'd0, bus.cmt_ready_o}, 128'h1);
        tick();
        chk("rr4_rd",    {123'd0, bus.wb_rd_o},    128'd1);
        chk("rr4_valid", {127'd0, bus.wb_valid_o}, 128'd1);

        // Reset mid-stream: valid drops, pointer back to unit 0.
        rst_n = 1'b0;
        tick();
        chk("midrst_valid", {127'd0, bus.wb_valid_o}, 128'd0);
        chk("midrst_rd",    {123'd0, bus.wb_rd_o},    128'd0);
        chk("midrst_ready", {124'd0, bus.cmt_ready_o}, 128'h0);
        rst_n = 1'b1;
        #1;
        chk("midrst_ptr0", {124'd0, bus.cmt_ready_o}, 128'h1);
        bus.cmt_valid_i = 4'h0;
        tick();
        chk("idle_valid", {127'd0, bus.wb_valid_o}, 128'd0);

        // Unit 2 alone with a distinctive payload.
        set_unit(2, 2'd3, 4'b1010, 5'd7, d2);
        bus.cmt_valid_i = 4'b0100;
        #1;
        chk("u2_ready", {124'd0, bus.cmt_ready_o}, 128'h4);
        tick();
        chk("u2_valid", {127'd0, bus.wb_valid_o}, 128'd1);
        chk("u2_wid",   {126'd0, bus.wb_wid_o},   128'd3);
        chk("u2_rd",    {123'd0, bus.wb_rd_o},    128'd7);
        chk("u2_tmask", {124'd0, bus.wb_tmask_o}, 128'hA);
        chk("u2_data",  bus.wb_data_o, d2);
        bus.cmt_valid_i = 4'h0;
        tick();
        chk("drain_valid", {127'd0, bus.wb_valid_o}, 128'd0);
        chk("drain_hold_rd", {123'd0, bus.wb_rd_o}, 128'd7);

        // Unit 1 commits rd=0 (pointer at 3): consumed, no writeback, unit 2 next.
        set_unit(1, 2'd1, 4'hF, 5'd0, 128'h11);
        set_unit(2, 2'd2, 4'hF, 5'd9, 128'h22);
        bus.cmt_valid_i = 4'b0110;
        #1;
        chk("rd0_ready", {124'd0, bus.cmt_ready_o}, 128'h2);
        tick();
        chk("rd0_no_wb", {127'd0, bus.wb_valid_o}, 128'd0);
        chk("rd0_next_ready", {124'd0, bus.cmt_ready_o}, 128'h4);
        tick();
        chk("after_rd0_valid", {127'd0, bus.wb_valid_o}, 128'd1);
        chk("after_rd0_rd",    {123'd0, bus.wb_rd_o},    128'd9);

        // Back-pressure for 3 cycles with units 0 and 3 waiting (pointer at 3).
        bus.wb_ready_i  = 1'b0;
        bus.cmt_valid_i = 4'b1001;
        #1;
        chk("bp_ready0", {124'd0, bus.cmt_ready_o}, 128'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_valid", {127'd0, bus.wb_valid_o}, 128'd1);
            chk("bp_rd",    {123'd0, bus.wb_rd_o},    128'd9);
            chk("bp_data",  bus.wb_data_o,            128'h22);
            chk("bp_ready", {124'd0, bus.cmt_ready_o}, 128'h0);
        end
        bus.wb_ready_i = 1'b1;
        #1;
        chk("rel_ready", {124'd0, bus.cmt_ready_o}, 128'h8);
        tick();
        chk("rel_u3_rd", {123'd0, bus.wb_rd_o}, 128'd4);
        chk("rel_u0_ready", {124'd0, bus.cmt_ready_o}, 128'h1);
        bus.cmt_valid_i = 4'b0001;
        tick();
        chk("rel_u0_rd", {123'd0, bus.wb_rd_o}, 128'd1);
        chk("rel_u0_valid", {127'd0, bus.wb_valid_o}, 128'd1);

        // tmask=0 passes through unchanged (pointer now 1, unit 0 alone).
        set_unit(0, 2'd2, 4'h0, 5'd5, 128'h55);
        tick();
        chk("tm0_valid", {127'd0, bus.wb_valid_o}, 128'd1);
        chk("tm0_tmask", {124'd0, bus.wb_tmask_o}, 128'h0);
        chk("tm0_rd",    {123'd0, bus.wb_rd_o},    128'd5);
        bus.cmt_valid_i = 4'h0;
        tick();
        chk("tm0_drain", {127'd0, bus.wb_valid_o}, 128'd0);

`ifdef WB_ARB_PERF_EN
        // Counters: 10 cycles with units 0 and 1 valid, ready high.
        rst_n = 1'b0;
        bus.cmt_valid_i = 4'b0011;
        set_unit(0, 2'd0, 4'hF, 5'd1, 128'h1);
        set_unit(1, 2'd1, 4'hF, 5'd2, 128'h2);
        tick();
        chk("perf_rst_wb",   {96'd0, perf_wb},   128'd0);
        chk("perf_rst_conf", {96'd0, perf_conf}, 128'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
        end
        chk("perf_conf", {96'd0, perf_conf}, 128'd10);
        chk("perf_wb",   {96'd0, perf_wb},   128'd9);
        bus.cmt_valid_i = 4'h0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed no completion, expected finish before 100000 ns");
        $fatal(1, "timeout");
    end

endmodule
